// File: rtl/batch_builder.sv
// Collects conflict-free transactions into batches, closes on full/timeout/force,
// then drains the batch's program IDs in arrival order to the executor.
module batch_builder #(
  parameter int unsigned MAX_BATCH_SIZE = 8,
  parameter int unsigned BATCH_TIMEOUT  = 64,
  parameter int unsigned ID_WIDTH       = 64,
  parameter int unsigned DEP_WIDTH      = 1024,
  parameter int unsigned BATCH_ID_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [ID_WIDTH-1:0]               s_axis_tdata_owner_programID,
  input  logic [DEP_WIDTH-1:0]              s_axis_tdata_read_dependencies,
  input  logic [DEP_WIDTH-1:0]              s_axis_tdata_write_dependencies,
  input  logic                              force_close,
  output logic                              batch_completed,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [ID_WIDTH-1:0]               m_axis_tdata_programID,
  output logic                              m_axis_tlast,
  output logic [BATCH_ID_WIDTH-1:0]         m_axis_tuser_batch_id,
  output logic [DEP_WIDTH-1:0]              batch_read_mask,
  output logic [DEP_WIDTH-1:0]              batch_write_mask,
  output logic [$clog2(MAX_BATCH_SIZE):0]   batch_size,
  output logic [31:0]                       batches_closed,
  output logic [31:0]                       timeout_closes
);

  localparam int unsigned SIZE_W = $clog2(MAX_BATCH_SIZE) + 1;
  localparam int unsigned PTR_W  = $clog2(MAX_BATCH_SIZE);
  localparam int unsigned TMR_W  = $clog2(BATCH_TIMEOUT + 1);

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] id_buf [MAX_BATCH_SIZE];
  logic [SIZE_W-1:0]   rd_ptr;
  logic [TMR_W-1:0]    timer;
  logic [BATCH_ID_WIDTH-1:0] batch_id;

  logic              accept;
  logic [SIZE_W-1:0] size_next;
  logic              close_full, close_timeout, close_force, close_now;
  logic              drain_hs, at_last;

  // Close decision and drain handshake, all from registered state
  always_comb begin
    accept        = s_axis_tvalid && (state_q == COLLECT);
    size_next     = batch_size + SIZE_W'(accept);
    close_full    = (size_next == SIZE_W'(MAX_BATCH_SIZE));
    close_timeout = (timer == TMR_W'(BATCH_TIMEOUT)) && (batch_size != '0);
    close_force   = force_close && ((batch_size != '0) || accept);
    close_now     = (state_q == COLLECT) && (close_full || close_timeout || close_force);
    at_last       = (rd_ptr == batch_size - SIZE_W'(1));
    drain_hs      = (state_q == DRAIN) && m_axis_tready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (close_now) state_d = DRAIN;
      DRAIN:   if (drain_hs && at_last) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // ID storage carries no reset; contents are meaningless outside a live batch
  always_ff @(posedge clk) begin
    if (accept) id_buf[batch_size[PTR_W-1:0]] <= s_axis_tdata_owner_programID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_size       <= '0;
      batch_read_mask  <= '0;
      batch_write_mask <= '0;
      timer            <= '0;
      rd_ptr           <= '0;
      batch_id         <= '0;
      batches_closed   <= '0;
      timeout_closes   <= '0;
      batch_completed  <= 1'b0;
    end else begin
      batch_completed <= close_now;
      if (state_q == COLLECT) begin
        if (accept) begin
          batch_size       <= size_next;
          batch_read_mask  <= batch_read_mask  | s_axis_tdata_read_dependencies;
          batch_write_mask <= batch_write_mask | s_axis_tdata_write_dependencies;
        end
        if (accept && (batch_size == '0))
          timer <= '0;
        else if ((batch_size != '0) && (timer != TMR_W'(BATCH_TIMEOUT)))
          timer <= timer + TMR_W'(1);
        if (close_now) begin
          rd_ptr         <= '0;
          batches_closed <= batches_closed + 32'd1;
          if (close_timeout && !close_full) timeout_closes <= timeout_closes + 32'd1;
        end
      end else if (drain_hs) begin
        rd_ptr <= rd_ptr + SIZE_W'(1);
        if (at_last) begin
          batch_size       <= '0;
          batch_read_mask  <= '0;
          batch_write_mask <= '0;
          timer            <= '0;
          batch_id         <= batch_id + BATCH_ID_WIDTH'(1);
        end
      end
    end
  end

  assign s_axis_tready          = (state_q == COLLECT);
  assign m_axis_tvalid          = (state_q == DRAIN);
  assign m_axis_tdata_programID = (state_q == DRAIN) ? id_buf[rd_ptr[PTR_W-1:0]] : '0;
  assign m_axis_tlast           = (state_q == DRAIN) && at_last;
  assign m_axis_tuser_batch_id  = batch_id;

endmodule

// File: tb/tb_batch_builder.sv
// Directed self-checking bench for batch_builder with MAX_BATCH_SIZE=4, BATCH_TIMEOUT=8.
module tb_batch_builder;

  localparam int unsigned MAX  = 4;
  localparam int unsigned TOUT = 8;
  localparam int unsigned IDW  = 64;
  localparam int unsigned DEPW = 1024;
  localparam int unsigned BIDW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_tvalid;
  logic              s_tready;
  logic [IDW-1:0]    s_id;
  logic [DEPW-1:0]   s_rd, s_wr;
  logic              force_close;
  logic              batch_completed;
  logic              m_tvalid, m_tready, m_tlast;
  logic [IDW-1:0]    m_id;
  logic [BIDW-1:0]   m_bid;
  logic [DEPW-1:0]   rmask, wmask;
  logic [2:0]        bsize;
  logic [31:0]       closed, tclosed;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;

  batch_builder #(
    .MAX_BATCH_SIZE(MAX), .BATCH_TIMEOUT(TOUT), .ID_WIDTH(IDW),
    .DEP_WIDTH(DEPW), .BATCH_ID_WIDTH(BIDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata_owner_programID(s_id),
    .s_axis_tdata_read_dependencies(s_rd),
    .s_axis_tdata_write_dependencies(s_wr),
    .force_close(force_close), .batch_completed(batch_completed),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata_programID(m_id), .m_axis_tlast(m_tlast),
    .m_axis_tuser_batch_id(m_bid),
    .batch_read_mask(rmask), .batch_write_mask(wmask),
    .batch_size(bsize), .batches_closed(closed), .timeout_closes(tclosed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDW-1:0] id);
    s_tvalid = 1'b1;
    s_id     = id;
    tick();
    s_tvalid = 1'b0;
    s_rd     = '0;
    s_wr     = '0;
  endtask

  initial begin
    logic [IDW-1:0] ids [4];
    rst_n = 1'b0; s_tvalid = 1'b0; s_id = '0; s_rd = '0; s_wr = '0;
    force_close = 1'b0; m_tready = 1'b1;
    #22 rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", m_id, 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_bcomp", 64'(batch_completed), 64'd0);
    check("rst_bsize", 64'(bsize), 64'd0);
    check("rst_closed", 64'(closed), 64'd0);

    // Full batch of four, drained with tready held high
    push(64'hA); push(64'hB); push(64'hC); push(64'hD);
    check("full_s_tready", 64'(s_tready), 64'd0);
    check("full_bcomp", 64'(batch_completed), 64'd1);
    check("full_bsize", 64'(bsize), 64'd4);
    check("full_d0", m_id, 64'hA);
    check("full_bid", 64'(m_bid), 64'd0);
    tick();
    check("full_bcomp_once", 64'(batch_completed), 64'd0);
    check("full_d1", m_id, 64'hB);
    tick();
    check("full_d2", m_id, 64'hC);
    check("full_tlast_c", 64'(m_tlast), 64'd0);
    tick();
    check("full_d3", m_id, 64'hD);
    check("full_tlast_d", 64'(m_tlast), 64'd1);
    tick();
    check("full_end_tvalid", 64'(m_tvalid), 64'd0);
    check("full_end_s_tready", 64'(s_tready), 64'd1);
    check("full_next_bid", 64'(m_bid), 64'd1);
    check("full_closed", 64'(closed), 64'd1);
    check("full_tclosed", 64'(tclosed), 64'd0);

    // Single entry closed by timeout: accept edge, then 8 timer increments, then close
    s_rd = '0; s_wr = '0; s_rd[5] = 1'b1; s_wr[9] = 1'b1;
    push(64'h55);
    cnt = 0;
    for (int i = 0; i < 20 && s_tready; i++) begin
      tick();
      cnt++;
    end
    check("tout_edges", 64'(cnt), 64'd9);
    check("tout_bcomp", 64'(batch_completed), 64'd1);
    check("tout_rmask", rmask[63:0], 64'h20);
    check("tout_wmask", wmask[63:0], 64'h200);
    check("tout_rmask_hi", 64'(|rmask[DEPW-1:64]), 64'd0);
    check("tout_tclosed", 64'(tclosed), 64'd1);
    check("tout_closed", 64'(closed), 64'd2);
    check("tout_d0", m_id, 64'h55);
    check("tout_tlast", 64'(m_tlast), 64'd1);
    tick();
    check("tout_bid", 64'(m_bid), 64'd2);
    check("tout_mask_clr", rmask[63:0] | wmask[63:0], 64'd0);

    // Fourth entry lands on the same edge the timer expires: counts as a full close
    ids[0] = 64'h31; ids[1] = 64'h32; ids[2] = 64'h33; ids[3] = 64'h34;
    push(ids[0]); push(ids[1]); push(ids[2]);
    for (int i = 0; i < 6; i++) tick();
    check("race_open", 64'(s_tready), 64'd1);
    push(ids[3]);
    check("race_closed_now", 64'(s_tready), 64'd0);
    check("race_bsize", 64'(bsize), 64'd4);
    check("race_tclosed", 64'(tclosed), 64'd1);
    check("race_closed", 64'(closed), 64'd3);
    check("race_d0", m_id, ids[0]);

    // Drain with tready toggling each cycle
    for (int i = 0; i < 4; i++) begin
      m_tready = 1'b0;
      tick();
      check("stall_data", m_id, ids[i]);
      check("stall_tlast", 64'(m_tlast), 64'(i == 3));
      check("stall_s_tready", 64'(s_tready), 64'd0);
      m_tready = 1'b1;
      tick();
    end
    check("stall_end_tvalid", 64'(m_tvalid), 64'd0);
    check("stall_end_bid", 64'(m_bid), 64'd3);

    // force_close on an empty batch is ignored
    force_close = 1'b1;
    tick();
    force_close = 1'b0;
    check("fc_empty_open", 64'(s_tready), 64'd1);
    check("fc_empty_bcomp", 64'(batch_completed), 64'd0);
    check("fc_empty_closed", 64'(closed), 64'd3);

    // force_close with two entries
    push(64'h41); push(64'h42);
    force_close = 1'b1;
    tick();
    force_close = 1'b0;
    check("fc2_bcomp", 64'(batch_completed), 64'd1);
    check("fc2_bsize", 64'(bsize), 64'd2);
    check("fc2_d0", m_id, 64'h41);
    check("fc2_tlast0", 64'(m_tlast), 64'd0);
    m_tready = 1'b1;
    tick();
    check("fc2_d1", m_id, 64'h42);
    check("fc2_tlast1", 64'(m_tlast), 64'd1);
    check("fc2_closed", 64'(closed), 64'd4);

    // Asynchronous reset while draining
    m_tready = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mrst_tvalid", 64'(m_tvalid), 64'd0);
    check("mrst_tdata", m_id, 64'd0);
    check("mrst_tlast", 64'(m_tlast), 64'd0);
    check("mrst_s_tready", 64'(s_tready), 64'd1);
    check("mrst_closed", 64'(closed), 64'd0);
    check("mrst_bid", 64'(m_bid), 64'd0);
    check("mrst_bsize", 64'(bsize), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Accept and force_close in the same cycle into an empty batch
    s_rd = '0; s_wr = '0; s_rd[3] = 1'b1;
    force_close = 1'b1;
    push(64'h77);
    force_close = 1'b0;
    check("post_bcomp", 64'(batch_completed), 64'd1);
    check("post_bsize", 64'(bsize), 64'd1);
    check("post_rmask", rmask[63:0], 64'h8);
    check("post_wmask", wmask[63:0], 64'h0);
    check("post_d0", m_id, 64'h77);
    check("post_tlast", 64'(m_tlast), 64'd1);
    check("post_bid", 64'(m_bid), 64'd0);
    m_tready = 1'b1;
    tick();
    check("post_done", 64'(m_tvalid), 64'd0);
    check("post_bid_next", 64'(m_bid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
